// File: rtl/comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and
// the one-hot-or-empty eq/lt/gt result triple.
package comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } cmp_result_t;

    localparam cmp_result_t CMP_EQ   = 3'b100;
    localparam cmp_result_t CMP_LT   = 3'b010;
    localparam cmp_result_t CMP_GT   = 3'b001;
    localparam cmp_result_t CMP_NONE = 3'b000;

endpackage

// File: rtl/comparator_chunk.sv
// Purely combinational CHUNK-bit unsigned magnitude compare producing an
// eq/lt/gt triple. Exactly one bit of the result is set.
module comparator_chunk
    import comparator_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output cmp_result_t      o_res
);

    // Classify the two slices as equal, less or greater.
    always_comb begin
        o_res = CMP_NONE;
        if (i_a == i_b) begin
            o_res = CMP_EQ;
        end else if (i_a < i_b) begin
            o_res = CMP_LT;
        end else begin
            o_res = CMP_GT;
        end
    end

endmodule

// File: rtl/comparator_serial.sv
// Multi-cycle magnitude comparator. Operands are latched on the accepting
// edge and compared CHUNK bits per cycle from the MSB end; the compare stops
// on the first differing chunk.
//
// Handshake: start is sampled only while busy=0. On the accepting edge busy
// rises; on the completing edge done pulses for one cycle, busy falls and
// eq/lt/gt load the new result, which then holds until the next done. Since
// done implies IDLE, a start held during the done cycle is accepted on the
// following edge.
//
// Signed mode inverts the MSB of both operands at latch time: this maps
// two's-complement order onto unsigned order, so the stepping logic is
// identical for both modes.
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output state_t           dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK) + 1;
    localparam logic [WIDTH-1:0] MSB_BIT = WIDTH'(1) << (WIDTH - 1);

    // Reject parameterisations the stepping logic cannot handle.
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $fatal(1, "comparator_serial: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [CW-1:0]     r_step;
    logic              r_busy;
    logic              r_done;
    cmp_result_t       r_res;
    cmp_result_t       w_chunk_res;
    logic [WIDTH-1:0]  w_flip;

    assign w_flip = signed_mode ? MSB_BIT : '0;

    comparator_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a   (r_a[WIDTH-1 -: CHUNK]),
        .i_b   (r_b[WIDTH-1 -: CHUNK]),
        .o_res (w_chunk_res)
    );

    // FSM: latch operands on accept, then step one chunk per cycle until a
    // difference is found or the last chunk has been compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= CMP_NONE;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a ^ w_flip;
                        r_b     <= b ^ w_flip;
                        r_step  <= CW'(1);
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!w_chunk_res.eq) begin
                        r_res   <= w_chunk_res;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_step == CW'(NCHUNK)) begin
                        r_res   <= CMP_EQ;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_a    <= r_a << CHUNK;
                        r_b    <= r_b << CHUNK;
                        r_step <= r_step + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign eq        = r_res.eq;
    assign lt        = r_res.lt;
    assign gt        = r_res.gt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_comparator_serial.sv
// Bench for comparator_serial (WIDTH=8, CHUNK=2): directed handshake/reset
// scenarios followed by randomized operands checked against an arithmetic
// reference model.
module tb_comparator_serial;
    import comparator_pkg::*;

    localparam int W  = 8;
    localparam int CH = 2;
    localparam int NC = W / CH;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         signed_mode;
    logic         busy;
    logic         done;
    logic         eq;
    logic         lt;
    logic         gt;
    state_t       dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    comparator_serial #(
        .WIDTH (W),
        .CHUNK (CH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt),
        .dbg_state   (dbg_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: latency is set by the highest differing bit position, and
    // the verdict comes straight from integer comparison.
    function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                  input logic ts, output int j, output logic [2:0] res);
        logic [W-1:0] x;
        int hb;
        x  = ta ^ tb_;
        hb = -1;
        for (int i = 0; i < W; i++) if (x[i]) hb = i;
        j = (hb < 0) ? NC : NC - hb / CH;
        if (ta == tb_) res = 3'b100;
        else if (ts ? ($signed(ta) < $signed(tb_)) : (ta < tb_)) res = 3'b010;
        else res = 3'b001;
    endfunction

    // Drive a request and confirm it is accepted on the next edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; signed_mode = ts;
        @(posedge clk); #1;
        acc_cyc = cyc;
        chk("busy_after_accept", busy, 1);
        chk("done_after_accept", done, 0);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    endtask

    // Wait (bounded) for done and check latency and verdict.
    task automatic wait_done(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                             input string tag);
        int ej;
        logic [2:0] eres;
        model(ta, tb_, ts, ej, eres);
        while (!done && (cyc - acc_cyc) < 20) begin
            @(posedge clk); #1;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_latency"}, cyc - acc_cyc, ej);
        chk({tag, "_result"}, {eq, lt, gt}, eres);
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    // done must drop after one cycle while the verdict holds.
    task automatic check_pulse_end(input logic [2:0] held, input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_hold"}, {eq, lt, gt}, held);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           ej;
        logic [2:0]   eres;

        // Reset held for 2 cycles with start asserted.
        rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; signed_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_result", {eq, lt, gt}, 3'b000);
            chk("rst_state", dbg_state, IDLE);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);

        // Equal operands: full-length compare.
        start_op(8'h5A, 8'h5A, 1'b0);
        wait_done(8'h5A, 8'h5A, 1'b0, "eq_5a");
        check_pulse_end(3'b100, "eq_5a");

        // MSB chunk differs: unsigned then signed.
        start_op(8'h80, 8'h7F, 1'b0);
        wait_done(8'h80, 8'h7F, 1'b0, "u80_7f");
        check_pulse_end(3'b001, "u80_7f");
        start_op(8'h80, 8'h7F, 1'b1);
        wait_done(8'h80, 8'h7F, 1'b1, "s80_7f");
        check_pulse_end(3'b010, "s80_7f");

        // LSB chunk differs.
        start_op(8'h12, 8'h13, 1'b0);
        wait_done(8'h12, 8'h13, 1'b0, "u12_13");
        start_op(8'hFF, 8'hFE, 1'b1);
        wait_done(8'hFF, 8'hFE, 1'b1, "sff_fe");
        check_pulse_end(3'b001, "sff_fe");

        // start pulsed while busy must be ignored.
        start_op(8'h12, 8'h13, 1'b0);
        start = 1'b1; a = 8'h00; b = 8'hFF; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(8'h12, 8'h13, 1'b0, "busy_ignore");

        // Back-to-back: start held during the done cycle.
        start = 1'b1; a = 8'h01; b = 8'h01; signed_mode = 1'b0;
        @(posedge clk); #1;
        acc_cyc = cyc;
        chk("b2b_busy", busy, 1);
        chk("b2b_done", done, 0);
        @(negedge clk);
        start = 1'b0;
        wait_done(8'h01, 8'h01, 1'b0, "b2b");
        check_pulse_end(3'b100, "b2b");

        // Reset 2 cycles into a 4-step compare aborts it.
        start_op(8'h12, 8'h13, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", {eq, lt, gt}, 3'b000);
        chk("abort_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
        end
        start_op(8'hC3, 8'hC1, 1'b1);
        wait_done(8'hC3, 8'hC1, 1'b1, "after_abort");

        // Randomized operands, biased toward long equal prefixes.
        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0:       rb = W'($urandom_range(0, 255));
                1:       rb = ra;
                default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, ej, eres);
            start_op(ra, rb, rs);
            wait_done(ra, rb, rs, "rand");
            check_pulse_end(eres, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparator_serial.md
Name: comparator_serial

Overview:
- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands, with unsigned and two's-complement signed modes.
- Operands are compared CHUNK bits per cycle, MSB chunk first, and the block stops on the first chunk that differs.
- Uses a start/busy/done handshake and replaces fixed-width combinational comparators in datapaths that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of CHUNK (elaboration-time check, fatal if violated).
- CHUNK, 2, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of compare steps.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- signed_mode  input  1  1 = two's-complement compare; sampled on the accepting edge.
- busy  output  1  compare in progress.
- done  output  1  one-cycle completion pulse.
- eq  output  1  A == B (last result).
- lt  output  1  A < B (last result).
- gt  output  1  A > B (last result).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; busy=0, done=0, eq=0, lt=0, gt=0; operand shift registers cleared.
- Reset mid-operation: the compare is aborted, no done is produced, and outputs return to their reset values on that edge.
- States: IDLE, RUN. All outputs are registered.
- IDLE, start=1 at edge k:
  - latch a and b into shift registers; in signed mode the MSB of both is inverted at latch, after which the compare is unsigned;
  - state becomes RUN, busy=1 from edge k.
- RUN, each edge: compare the top CHUNK bits of both shift registers.
  - Chunks differ: eq/lt/gt are loaded from that chunk compare, done=1, busy=0, state becomes IDLE.
  - Chunks equal and not the last chunk: shift both registers left by CHUNK and stay in RUN.
  - Chunks equal and last chunk (step NCHUNK): eq=1, lt=0, gt=0, done=1, busy=0, state becomes IDLE.
- Latency: done asserts j edges after the accepting edge, where j = 1-based index of the first differing chunk from the MSB, or NCHUNK if the operands are equal. Range is 1..NCHUNK.
- done is high for exactly one cycle. eq/lt/gt update only on the done edge and hold until the next done.
  - After the first completion, exactly one of eq/lt/gt is 1.
  - Between reset and the first completion, all three are 0.
- start while busy=1 is ignored; operands are not disturbed.
- Back-to-back: done=1 implies state=IDLE, so start=1 in the done cycle is accepted. In the next cycle busy=1 and done=0.
- CHUNK=WIDTH degenerates to a fixed 1-cycle latency; this must work.
- No X propagation: a and b are don't-care outside the accepting edge.

Decomposition:
- Package comparator_pkg holds:
  - state typedef (IDLE, RUN);
  - cmp_result_t {eq, lt, gt} with constants CMP_EQ, CMP_LT, CMP_GT, CMP_NONE.
- Sub-module comparator_chunk: purely combinational CHUNK-bit unsigned compare, parameter CHUNK, producing an eq/lt/gt triple. It is instantiated once on the shift-register MSB slices.
- The FSM, shift registers, step counter ($clog2(NCHUNK)+1 bits) and output registers live in comparator_serial.

Test Plan (WIDTH=8, CHUNK=2; j = edges from accept to done):
- Reset: assert rst for 2 cycles with start=1 -> busy, done, eq, lt, gt all 0; no accept until rst drops.
- a=8'h5A, b=8'h5A, unsigned -> j=4, eq=1, lt=0, gt=0; done high for exactly one cycle.
- a=8'h80, b=8'h7F:
  - unsigned -> j=1, gt=1;
  - repeat with signed_mode=1 -> j=1, lt=1.
- a=8'h12, b=8'h13, unsigned -> j=4, lt=1. Then a=8'hFF, b=8'hFE, signed -> j=4, gt=1 (-1 > -2).
- Handshake:
  - start pulsed with a=8'h00, b=8'hFF while busy -> ignored; the running result is unchanged.
  - start held high during the done cycle with a=8'h01, b=8'h01 -> accepted, and eq=1 appears 4 edges later.
- Reset asserted 2 cycles into a 4-step compare -> no done pulse; all outputs 0 the next cycle; a following compare completes normally.
